// File: rtl/ps2_synth_pkg.sv
// Shared types, widths and constant tables for the PS/2 two-voice synth.
// Holds the envelope state enum, the scan-code to semitone map and the
// per-semitone DDS phase-increment table derived from FS_HZ and PHASE_W.
package ps2_synth_pkg;

  localparam int unsigned FS_HZ        = 48000;
  localparam int unsigned PHASE_W      = 24;
  localparam int unsigned ATTACK_STEP  = 4;
  localparam int unsigned RELEASE_STEP = 1;

  localparam int unsigned CODE_W    = 8;
  localparam int unsigned PAIR_W    = CODE_W + 1;
  localparam int unsigned NUM_KEYS  = 20;
  localparam int unsigned KEY_IDX_W = 5;
  localparam int unsigned ENV_W     = 8;
  localparam int unsigned TRI_W     = 12;
  localparam int unsigned MIX_SHIFT = 4;
  localparam int unsigned OUT_W     = TRI_W + MIX_SHIFT;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  // {on, code} as launched by the keyboard decoder
  typedef struct packed {
    logic              on;
    logic [CODE_W-1:0] code;
  } key_pair_t;

  typedef struct packed {
    logic                 valid;
    logic [KEY_IDX_W-1:0] idx;
  } key_idx_t;

  typedef logic [NUM_KEYS-1:0][PHASE_W-1:0] inc_lut_t;

  // Scan code to semitone above C4; anything unmapped (including f0) is invalid.
  function automatic key_idx_t key_to_index(input logic [CODE_W-1:0] code);
    key_idx_t r;
    r.valid = 1'b1;
    r.idx   = '0;
    case (code)
      8'h1c: r.idx = 5'd0;
      8'h1b: r.idx = 5'd1;
      8'h23: r.idx = 5'd2;
      8'h2b: r.idx = 5'd3;
      8'h34: r.idx = 5'd4;
      8'h33: r.idx = 5'd5;
      8'h3b: r.idx = 5'd6;
      8'h42: r.idx = 5'd7;
      8'h4b: r.idx = 5'd8;
      8'h4c: r.idx = 5'd9;
      8'h52: r.idx = 5'd10;
      8'h5b: r.idx = 5'd11;
      8'h15: r.idx = 5'd12;
      8'h1d: r.idx = 5'd13;
      8'h24: r.idx = 5'd14;
      8'h2c: r.idx = 5'd15;
      8'h35: r.idx = 5'd16;
      8'h43: r.idx = 5'd17;
      8'h44: r.idx = 5'd18;
      8'h4d: r.idx = 5'd19;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  // Equal-tempered note frequency in micro-hertz, C4 upward (A4 = 440 Hz).
  function automatic longint unsigned note_freq_uhz(input int unsigned idx);
    longint unsigned f;
    case (idx)
      0:  f = 64'd261_625_565;
      1:  f = 64'd277_182_631;
      2:  f = 64'd293_664_768;
      3:  f = 64'd311_126_984;
      4:  f = 64'd329_627_557;
      5:  f = 64'd349_228_231;
      6:  f = 64'd369_994_423;
      7:  f = 64'd391_995_436;
      8:  f = 64'd415_304_698;
      9:  f = 64'd440_000_000;
      10: f = 64'd466_163_762;
      11: f = 64'd493_883_301;
      12: f = 64'd523_251_131;
      13: f = 64'd554_365_262;
      14: f = 64'd587_329_536;
      15: f = 64'd622_253_967;
      16: f = 64'd659_255_114;
      17: f = 64'd698_456_463;
      18: f = 64'd739_988_845;
      default: f = 64'd783_990_872;
    endcase
    return f;
  endfunction

  // inc = round(f * 2^PHASE_W / FS_HZ), evaluated at elaboration only.
  function automatic inc_lut_t build_inc_lut();
    inc_lut_t        lut;
    longint unsigned num;
    longint unsigned den;
    den = 64'(FS_HZ) * 64'd1_000_000;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      num = note_freq_uhz(i) << PHASE_W;
      lut[KEY_IDX_W'(i)] = PHASE_W'((num + den / 64'd2) / den);
    end
    return lut;
  endfunction

  localparam inc_lut_t PHASE_INC_LUT = build_inc_lut();

endpackage

// File: rtl/ps2_key_voice_synth_voice.sv
// synth_voice: one key-driven voice.
// Filters the synchronized {on,code} pair for stability, runs the
// attack/sustain/release envelope, the DDS phase accumulator and the
// triangle shaper, and scales the triangle by the envelope.
// Ports: sys_clk/reset, sample_tick strobe, pair_s1/pair_s2 (first and
// second synchronizer stages), active (registered, state != IDLE),
// voice_c (combinational signed voice level from registered phase/env).
module synth_voice
  import ps2_synth_pkg::*;
(
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [PAIR_W-1:0] pair_s1,
  input  logic [PAIR_W-1:0] pair_s2,
  output logic              active,
  output logic [TRI_W-1:0]  voice_c
);

  localparam int unsigned ENV_SUM_W = ENV_W + 1;
  localparam int unsigned TRI_MAG_W = TRI_W - 1;
  localparam int unsigned TRI_HALF  = 1 << (TRI_W - 2);
  localparam int unsigned PROD_W    = TRI_W + ENV_W + 1;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  env_state_t          state, state_next;
  logic [ENV_W-1:0]    env, env_next;
  logic [PHASE_W-1:0]  phase, phase_next;
  logic [PHASE_W-1:0]  inc, inc_next;
  logic [CODE_W-1:0]   cur_code, code_next;

  key_pair_t           pair;
  key_idx_t            key_info;
  logic                stable;
  logic                key_ok;
  logic                code_changed;
  logic [ENV_SUM_W-1:0] env_up;

  // Both synchronizer stages agree => the pair was steady for two cycles.
  assign pair         = pair_s2;
  assign stable       = (pair_s1 == pair_s2);
  assign key_info     = key_to_index(pair.code);
  assign key_ok       = pair.on & key_info.valid;
  assign code_changed = (pair.code != cur_code);
  assign env_up       = {1'b0, env} + ENV_SUM_W'(ATTACK_STEP);

  // Envelope FSM plus phase/env datapath next values
  always_comb begin
    state_next = state;
    env_next   = env;
    phase_next = phase;
    inc_next   = inc;
    code_next  = cur_code;

    if (sample_tick) begin
      case (state)
        ENV_ATTACK:  env_next = (env_up > {1'b0, ENV_MAX}) ? ENV_MAX : env_up[ENV_W-1:0];
        ENV_RELEASE: env_next = (env > ENV_W'(RELEASE_STEP)) ? env - ENV_W'(RELEASE_STEP) : '0;
        default:     env_next = env;
      endcase
      if (state != ENV_IDLE) phase_next = phase + inc;
    end

    case (state)
      ENV_IDLE: begin
        if (stable && key_ok) begin
          state_next = ENV_ATTACK;
          inc_next   = PHASE_INC_LUT[key_info.idx];
          code_next  = pair.code;
          phase_next = '0;
        end
      end
      ENV_ATTACK, ENV_SUSTAIN: begin
        if (stable && !key_ok) begin
          state_next = ENV_RELEASE;
        end else if (stable && code_changed) begin
          // new note while held: re-attack from the current level and phase
          state_next = ENV_ATTACK;
          inc_next   = PHASE_INC_LUT[key_info.idx];
          code_next  = pair.code;
        end else if (state == ENV_ATTACK && sample_tick && env_next == ENV_MAX) begin
          state_next = ENV_SUSTAIN;
        end
      end
      ENV_RELEASE: begin
        if (stable && key_ok) begin
          state_next = ENV_ATTACK;
          inc_next   = PHASE_INC_LUT[key_info.idx];
          code_next  = pair.code;
        end else if (sample_tick && env_next == '0) begin
          state_next = ENV_IDLE;
        end
      end
      default: state_next = ENV_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state    <= ENV_IDLE;
      env      <= '0;
      phase    <= '0;
      inc      <= '0;
      cur_code <= '0;
      active   <= 1'b0;
    end else begin
      state    <= state_next;
      env      <= env_next;
      phase    <= phase_next;
      inc      <= inc_next;
      cur_code <= code_next;
      active   <= (state_next != ENV_IDLE);
    end
  end

  logic [TRI_MAG_W-1:0]    tri_mag;
  logic signed [TRI_W-1:0] tri_s;
  logic signed [PROD_W-1:0] prod;

  // Fold the upper phase bits into a symmetric triangle, centre on zero, scale by env
  always_comb begin
    tri_mag = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: TRI_MAG_W]
                               :  phase[PHASE_W-2 -: TRI_MAG_W];
    tri_s   = $signed({1'b0, tri_mag} - TRI_W'(TRI_HALF));
    prod    = PROD_W'(tri_s) * PROD_W'($signed({1'b0, env}));
    voice_c = TRI_W'(prod >>> ENV_W);
  end

endmodule

// File: rtl/ps2_key_voice_synth.sv
// ps2_key_voice_synth: two-voice key synth behind the PS/2 decoder.
// Resynchronizes both key pairs from the ps2_clk domain, runs one
// synth_voice per key and registers the mixed sample one cycle after
// each sample_tick.
// Ports: sys_clk, reset (async, active-high), sample_tick strobe,
// key1_on/key1_code and key2_on/key2_code (ps2_clk domain),
// sample_out (signed 16-bit), sample_valid strobe, voice_active[1:0].
module ps2_key_voice_synth
  import ps2_synth_pkg::*;
(
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              key1_on,
  input  logic [7:0]        key1_code,
  input  logic              key2_on,
  input  logic [7:0]        key2_code,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic [1:0]        voice_active
);

  logic [PAIR_W-1:0] k1_s1, k1_s2;
  logic [PAIR_W-1:0] k2_s1, k2_s2;
  logic              tick_d;
  logic [TRI_W-1:0]  v0_c, v1_c;
  logic signed [TRI_W-1:0] mix_c;

  // Two-flop synchronizers for both key pairs, plus tick delay for output timing
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      k1_s1  <= '0;
      k1_s2  <= '0;
      k2_s1  <= '0;
      k2_s2  <= '0;
      tick_d <= 1'b0;
    end else begin
      k1_s1  <= {key1_on, key1_code};
      k1_s2  <= k1_s1;
      k2_s1  <= {key2_on, key2_code};
      k2_s2  <= k2_s1;
      tick_d <= sample_tick;
    end
  end

  synth_voice u_voice0 (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .pair_s1     (k1_s1),
    .pair_s2     (k1_s2),
    .active      (voice_active[0]),
    .voice_c     (v0_c)
  );

  synth_voice u_voice1 (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .pair_s1     (k2_s1),
    .pair_s2     (k2_s2),
    .active      (voice_active[1]),
    .voice_c     (v1_c)
  );

  // Voices are bounded to +/-1020, so the 12-bit sum cannot overflow
  assign mix_c = $signed(v0_c) + $signed(v1_c);

  // Output register, loaded the cycle after the tick updated phase/env
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick_d;
      if (tick_d) sample_out <= {mix_c, {MIX_SHIFT{1'b0}}};
    end
  end

endmodule

// File: tb/tb_ps2_key_voice_synth.sv
// Bench for ps2_key_voice_synth: directed key/tick sequences, a
// note-level reference model and literal spot values.
module tb_ps2_key_voice_synth;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        key1_on = 1'b0;
  logic [7:0]  key1_code = 8'h00;
  logic        key2_on = 1'b0;
  logic [7:0]  key2_code = 8'h00;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [1:0]  voice_active;

  always #5 sys_clk = ~sys_clk;

  ps2_key_voice_synth dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .key1_on      (key1_on),
    .key1_code    (key1_code),
    .key2_on      (key2_on),
    .key2_code    (key2_code),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .voice_active (voice_active)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ATTACK = 1, M_SUSTAIN = 2, M_RELEASE = 3;
  localparam int PH_MOD = 16777216;

  logic [7:0] key_codes [20] = '{8'h1c, 8'h1b, 8'h23, 8'h2b, 8'h34, 8'h33, 8'h3b,
                                 8'h42, 8'h4b, 8'h4c, 8'h52, 8'h5b, 8'h15, 8'h1d,
                                 8'h24, 8'h2c, 8'h35, 8'h43, 8'h44, 8'h4d};

  int         m_st  [2] = '{0, 0};
  int         m_env [2] = '{0, 0};
  int         m_ph  [2] = '{0, 0};
  int         m_inc [2] = '{0, 0};
  logic [7:0] m_code[2] = '{8'h00, 8'h00};
  logic [8:0] m_h1  [2] = '{9'h0, 9'h0};
  logic [8:0] m_h2  [2] = '{9'h0, 9'h0};
  bit         m_tick_d = 1'b0;
  bit         m_valid = 1'b0;
  int         m_sample = 0;

  function automatic int code_idx(input logic [7:0] c);
    for (int i = 0; i < 20; i++) if (key_codes[i] == c) return i;
    return -1;
  endfunction

  function automatic int note_inc(input int idx);
    real f;
    f = 440.0 * (2.0 ** ((idx - 9) / 12.0));
    return $rtoi(f * 16777216.0 / 48000.0 + 0.5);
  endfunction

  function automatic int voice_level(input int phase, input int env);
    int t;
    int tri_v;
    t = (phase >> 12) & 2047;
    if (((phase >> 23) & 1) == 1) t = 2047 - t;
    tri_v = t - 1024;
    return (tri_v * env) >>> 8;
  endfunction

  task automatic step_voice(input int v, input bit tick);
    bit steady;
    bit ok;
    int idx;
    int env2;
    int ph2;
    steady = (m_h1[v] == m_h2[v]);
    idx    = code_idx(m_h2[v][7:0]);
    ok     = m_h2[v][8] && (idx >= 0);
    env2   = m_env[v];
    ph2    = m_ph[v];
    if (tick) begin
      if (m_st[v] == M_ATTACK)  env2 = (env2 + 4 > 255) ? 255 : env2 + 4;
      if (m_st[v] == M_RELEASE) env2 = (env2 > 1) ? env2 - 1 : 0;
      if (m_st[v] != M_IDLE)    ph2 = (ph2 + m_inc[v]) % PH_MOD;
    end
    if (m_st[v] == M_IDLE) begin
      if (steady && ok) begin
        m_st[v] = M_ATTACK; m_inc[v] = note_inc(idx); m_code[v] = m_h2[v][7:0]; ph2 = 0;
      end
    end else if (m_st[v] == M_RELEASE) begin
      if (steady && ok) begin
        m_st[v] = M_ATTACK; m_inc[v] = note_inc(idx); m_code[v] = m_h2[v][7:0];
      end else if (tick && env2 == 0) begin
        m_st[v] = M_IDLE;
      end
    end else begin
      if (steady && !ok) m_st[v] = M_RELEASE;
      else if (steady && m_h2[v][7:0] != m_code[v]) begin
        m_st[v] = M_ATTACK; m_inc[v] = note_inc(idx); m_code[v] = m_h2[v][7:0];
      end else if (m_st[v] == M_ATTACK && tick && env2 == 255) m_st[v] = M_SUSTAIN;
    end
    m_env[v] = env2;
    m_ph[v]  = ph2;
  endtask

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < 2; v++) begin
        m_st[v] = M_IDLE; m_env[v] = 0; m_ph[v] = 0; m_inc[v] = 0;
        m_code[v] = 8'h00; m_h1[v] = 9'h0; m_h2[v] = 9'h0;
      end
      m_tick_d = 1'b0; m_valid = 1'b0; m_sample = 0;
    end else begin
      m_valid = m_tick_d;
      if (m_tick_d)
        m_sample = 16 * (voice_level(m_ph[0], m_env[0]) + voice_level(m_ph[1], m_env[1]));
      step_voice(0, sample_tick);
      step_voice(1, sample_tick);
      m_h2 = m_h1;
      m_h1[0] = {key1_on, key1_code};
      m_h1[1] = {key2_on, key2_code};
      m_tick_d = sample_tick;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge sys_clk) begin
    if (!reset) begin
      check("cyc_sample_out", $signed(sample_out), m_sample);
      check("cyc_sample_valid", sample_valid, m_valid);
      check("cyc_voice_active", voice_active, {m_st[1] != M_IDLE, m_st[0] != M_IDLE});
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_ticks(input int n);
    repeat (n) begin
      @(negedge sys_clk); sample_tick = 1'b1;
      @(negedge sys_clk); sample_tick = 1'b0;
      repeat (5) @(negedge sys_clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_sample_out", $signed(sample_out), 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_voice_active", voice_active, 0);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);

    // A4 on voice 0: active three edges after the change
    key1_on = 1'b1; key1_code = 8'h4c;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("latency_edge2", voice_active, 2'b00);
    @(negedge sys_clk);
    check("latency_edge3", voice_active, 2'b01);
    repeat (2) @(negedge sys_clk);

    do_ticks(4);
    check("a4_4t_sample", $signed(sample_out), -880);
    check("a4_4t_env", m_env[0], 16);
    check("a4_4t_phase", m_ph[0], 615164);

    do_ticks(60);
    check("a4_64t_sample", $signed(sample_out), 10656);
    check("a4_64t_env", m_env[0], 255);
    check("a4_64t_state", m_st[0], M_SUSTAIN);
    check("a4_64t_phase", m_ph[0], 9842624);
    do_ticks(6);

    // Release: 255 ticks back to IDLE
    key1_on = 1'b0;
    repeat (4) @(negedge sys_clk);
    check("rel_active", voice_active, 2'b01);
    do_ticks(254);
    check("rel_254_active", voice_active, 2'b01);
    do_ticks(1);
    check("rel_255_active", voice_active, 2'b00);
    check("rel_255_sample", $signed(sample_out), 0);

    // Two voices together
    key1_on = 1'b1; key1_code = 8'h1c;
    key2_on = 1'b1; key2_code = 8'h4c;
    repeat (4) @(negedge sys_clk);
    do_ticks(1);
    check("dual_1t_sample", $signed(sample_out), -512);
    check("dual_active", voice_active, 2'b11);
    @(negedge sys_clk); sample_tick = 1'b1;
    @(negedge sys_clk); sample_tick = 1'b0;
    check("valid_t1", sample_valid, 0);
    @(negedge sys_clk);
    check("valid_t2", sample_valid, 1);
    @(negedge sys_clk);
    check("valid_t3", sample_valid, 0);
    repeat (3) @(negedge sys_clk);
    do_ticks(20);

    // Note change while held on voice 1
    key2_code = 8'h15;
    repeat (4) @(negedge sys_clk);
    do_ticks(30);
    key1_on = 1'b0; key2_on = 1'b0;
    repeat (4) @(negedge sys_clk);
    do_ticks(10);

    // Clean restart
    reset = 1'b1;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
    check("pulse_rst_active", voice_active, 2'b00);

    // Invalid codes never start a voice
    key1_on = 1'b1; key1_code = 8'hf0;
    repeat (6) @(negedge sys_clk);
    do_ticks(2);
    check("inv_f0_active", voice_active, 2'b00);
    check("inv_f0_sample", $signed(sample_out), 0);
    key1_code = 8'h5a;
    repeat (6) @(negedge sys_clk);
    do_ticks(2);
    check("inv_5a_active", voice_active, 2'b00);
    check("inv_5a_sample", $signed(sample_out), 0);
    key1_on = 1'b0; key1_code = 8'h00;
    repeat (4) @(negedge sys_clk);

    // Single-cycle glitch is ignored
    @(negedge sys_clk); key1_on = 1'b1; key1_code = 8'h4c;
    @(negedge sys_clk); key1_on = 1'b0; key1_code = 8'h00;
    repeat (6) @(negedge sys_clk);
    check("glitch_active", voice_active, 2'b00);

    // Code glitch during a held note does not retune it
    key1_on = 1'b1; key1_code = 8'h4c;
    repeat (4) @(negedge sys_clk);
    do_ticks(2);
    @(negedge sys_clk); key1_code = 8'h1c;
    @(negedge sys_clk); key1_code = 8'h4c;
    repeat (4) @(negedge sys_clk);
    do_ticks(3);
    check("glitch_held_inc", m_inc[0], 153791);

    // Reset mid-attack while the tick is high
    @(negedge sys_clk); sample_tick = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("midrst_sample_out", $signed(sample_out), 0);
    check("midrst_sample_valid", sample_valid, 0);
    check("midrst_voice_active", voice_active, 0);
    @(negedge sys_clk); sample_tick = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("restart_active", voice_active, 2'b01);
    repeat (2) @(negedge sys_clk);
    do_ticks(4);
    check("restart_4t_sample", $signed(sample_out), -880);
    check("restart_4t_phase", m_ph[0], 615164);
    key1_on = 1'b0;
    repeat (4) @(negedge sys_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
